// File: rtl/iterative_shifter_pkg.sv
// Shared types and constants for the iterative shifter.
// Optional arithmetic right shift is enabled by defining ITER_SHIFTER_ARITH_EN.
package iter_shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/iterative_shifter_if.sv
// Request/result handshake bundle for the iterative shifter.
// The in_arith signal exists only when ITER_SHIFTER_ARITH_EN is defined.
interface iterative_shifter_if #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
);
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [SW-1:0] in_amount;
  logic          in_dir;
`ifdef ITER_SHIFTER_ARITH_EN
  logic          in_arith;
`endif
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;

  // Requester side: issues requests and consumes results.
  modport master (
    output in_valid, in_data, in_amount, in_dir,
`ifdef ITER_SHIFTER_ARITH_EN
    output in_arith,
`endif
    output out_ready,
    input  in_ready, out_valid, out_data
  );

  // Shifter side.
  modport slave (
    input  in_valid, in_data, in_amount, in_dir,
`ifdef ITER_SHIFTER_ARITH_EN
    input  in_arith,
`endif
    input  out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/iterative_shifter_shift_step_by_one.sv
// Combinational one-position shifter; the caller chooses the fill bit.
module shift_step_by_one
  import iter_shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] word_i,
  input  logic         dir_i,
  input  logic         fill_i,
  output logic [N-1:0] word_o
);

  // Move every bit one place and insert the fill bit at the vacated end.
  always_comb begin
    word_o = {word_i[N-2:0], fill_i};
    if (dir_i == DIR_RIGHT) begin
      word_o = {fill_i, word_i[N-1:1]};
    end
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle logical shifter: one bit position per clock, valid/ready on
// both sides. Define ITER_SHIFTER_ARITH_EN to add arithmetic right shifts.
module iterative_shifter
  import iter_shift_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  iterative_shifter_if.slave bus
);

  state_e        state_q, state_d;
  logic [N-1:0]  work_q, work_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic [N-1:0]  step_w;
  logic          fill_w;
`ifdef ITER_SHIFTER_ARITH_EN
  logic          arith_q, arith_d;

  // Sign extension only applies to right shifts flagged arithmetic.
  assign fill_w = (dir_q == DIR_RIGHT) && arith_q ? work_q[N-1] : 1'b0;
`else
  assign fill_w = 1'b0;
`endif

  shift_step_by_one #(.N(N)) u_step (
    .word_i (work_q),
    .dir_i  (dir_q),
    .fill_i (fill_w),
    .word_o (step_w)
  );

  // Outputs are decoded from registered state only, so there is no
  // combinational path from in_valid or out_ready.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = work_q;

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_LEFT;
`ifdef ITER_SHIFTER_ARITH_EN
      arith_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
`ifdef ITER_SHIFTER_ARITH_EN
      arith_q <= arith_d;
`endif
    end
  end

  // Next-state logic: capture in IDLE, step in SHIFT, hold in DONE.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
`ifdef ITER_SHIFTER_ARITH_EN
    arith_d = arith_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d = bus.in_data;
          cnt_d  = bus.in_amount;
          dir_d  = bus.in_dir;
`ifdef ITER_SHIFTER_ARITH_EN
          arith_d = bus.in_arith;
`endif
          state_d = (bus.in_amount == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        work_d = step_w;
        cnt_d  = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_iterative_shifter.sv
// Self-checking bench for iterative_shifter (N = 8) with a reference model
// built from shift operators. Arithmetic cases run when ITER_SHIFTER_ARITH_EN
// is defined.
module tb_iterative_shifter;
  localparam int N  = 8;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  iterative_shifter_if #(.N(N), .SW(SW)) bus ();

  iterative_shifter #(.N(N), .SW(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [7:0] d, input int a,
                                       input logic dir, input logic ar);
    logic signed [7:0] s;
    s = d;
    if (dir == 1'b0) return d << a;
    if (ar) return s >>> a;
    return d >> a;
  endfunction

  task automatic drive_req(input logic [7:0] d, input logic [2:0] a,
                           input logic dir, input logic ar);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_amount = a;
    bus.in_dir    = dir;
`ifdef ITER_SHIFTER_ARITH_EN
    bus.in_arith  = ar;
`else
    if (ar) bus.in_dir = dir;
`endif
  endtask

  task automatic scramble_inputs();
    bus.in_data   = 8'($urandom);
    bus.in_amount = 3'($urandom);
    bus.in_dir    = 1'($urandom);
`ifdef ITER_SHIFTER_ARITH_EN
    bus.in_arith  = 1'($urandom);
`endif
  endtask

  // Stimulus only: issues one request, returns result and cycles to out_valid.
  task automatic run_op(input logic [7:0] d, input logic [2:0] a, input logic dir,
                        input logic ar, input int hold,
                        output logic [7:0] res, output int lat);
    int w;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait in_ready=%b required 1", bus.in_ready);
    end
    drive_req(d, a, dir, ar);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    scramble_inputs();
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    repeat (hold) @(negedge clk);
    res = bus.out_data;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_during rdy=%b vld=%b data=%h required 1 0 00",
               bus.in_ready, bus.out_valid, bus.out_data);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_after rdy=%b vld=%b data=%h required 1 0 00",
               bus.in_ready, bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_directed();
    logic [7:0] res;
    int lat;
    run_op(8'b1011_0101, 3'd3, 1'b0, 1'b0, 0, res, lat);
    checks++;
    if (res !== 8'b1010_1000) begin
      errors++; $display("FAIL left3_data got %h required a8", res);
    end
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL left3_latency got %0d required 4", lat);
    end
    run_op(8'b1011_0101, 3'd3, 1'b1, 1'b0, 0, res, lat);
    checks++;
    if (res !== 8'b0001_0110) begin
      errors++; $display("FAIL right3_data got %h required 16", res);
    end
    run_op(8'h5A, 3'd0, 1'b0, 1'b0, 0, res, lat);
    checks++;
    if (res !== 8'h5A || lat !== 1) begin
      errors++; $display("FAIL amount0 got %h lat %0d required 5a lat 1", res, lat);
    end
    run_op(8'h81, 3'd7, 1'b0, 1'b0, 0, res, lat);
    checks++;
    if (res !== 8'h80 || lat !== 8) begin
      errors++; $display("FAIL left7 got %h lat %0d required 80 lat 8", res, lat);
    end
    run_op(8'h81, 3'd7, 1'b1, 1'b0, 0, res, lat);
    checks++;
    if (res !== 8'h01 || lat !== 8) begin
      errors++; $display("FAIL right7 got %h lat %0d required 01 lat 8", res, lat);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    drive_req(8'h0F, 3'd4, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 5) begin
      errors++; $display("FAIL bp_latency got %0d required 5", lat);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_data !== 8'hF0 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d data=%h vld=%b rdy=%b required f0 1 0",
                 i, bus.out_data, bus.out_valid, bus.in_ready);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release rdy=%b vld=%b required 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    drive_req(8'hC3, 3'd2, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    // Second request held valid while the first is busy; it must not disturb it.
    drive_req(8'h3C, 3'd1, 1'b0, 1'b0);
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (bus.out_data !== 8'h30 || lat !== 3) begin
      errors++;
      $display("FAIL b2b_first got %h lat %0d required 30 lat 3", bus.out_data, lat);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_ready got %b required 1", bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (bus.out_data !== 8'h78 || lat !== 2) begin
      errors++;
      $display("FAIL b2b_second got %h lat %0d required 78 lat 2", bus.out_data, lat);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] res;
    int lat;
    int seen;
    drive_req(8'hA7, 3'd5, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL abort_no_valid got %0d valid cycles required 0", seen);
    end
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_data !== 8'h00) begin
      errors++;
      $display("FAIL abort_state rdy=%b data=%h required 1 00", bus.in_ready, bus.out_data);
    end
    run_op(8'h96, 3'd5, 1'b1, 1'b0, 0, res, lat);
    checks++;
    if (res !== 8'h04 || lat !== 6) begin
      errors++; $display("FAIL abort_recover got %h lat %0d required 04 lat 6", res, lat);
    end
  endtask

`ifdef ITER_SHIFTER_ARITH_EN
  task automatic test_arith();
    logic [7:0] res;
    int lat;
    run_op(8'h80, 3'd7, 1'b1, 1'b1, 0, res, lat);
    checks++;
    if (res !== 8'hFF) begin
      errors++; $display("FAIL arith_on got %h required ff", res);
    end
    run_op(8'h80, 3'd7, 1'b1, 1'b0, 0, res, lat);
    checks++;
    if (res !== 8'h01) begin
      errors++; $display("FAIL arith_off got %h required 01", res);
    end
    run_op(8'h81, 3'd3, 1'b0, 1'b1, 0, res, lat);
    checks++;
    if (res !== 8'h08) begin
      errors++; $display("FAIL arith_left got %h required 08", res);
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] d, res, exp;
    logic [2:0] a;
    logic dir, ar;
    int lat, hold;
    for (int i = 0; i < 60; i++) begin
      d    = 8'($urandom);
      a    = 3'($urandom);
      dir  = 1'($urandom);
`ifdef ITER_SHIFTER_ARITH_EN
      ar   = 1'($urandom);
`else
      ar   = 1'b0;
`endif
      hold = $urandom_range(0, 3);
      exp  = model(d, int'(a), dir, ar);
      run_op(d, a, dir, ar, hold, res, lat);
      checks++;
      if (res !== exp || lat !== int'(a) + 1) begin
        errors++;
        $display("FAIL rand%0d d=%h a=%0d dir=%b ar=%b got %h lat %0d required %h lat %0d",
                 i, d, a, dir, ar, res, lat, exp, int'(a) + 1);
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amount = '0;
    bus.in_dir    = 1'b0;
`ifdef ITER_SHIFTER_ARITH_EN
    bus.in_arith  = 1'b0;
`endif
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef ITER_SHIFTER_ARITH_EN
    test_arith();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iterative_shifter.md
# iterative_shifter

Multi-cycle logical shifter for an N-bit word. It accepts a word, a shift amount and a direction over a valid/ready handshake, then shifts one bit position per clock. The result is presented on a valid/ready output. It is the sequential, area-lean counterpart to the single-cycle shift blocks, for datapaths that trade latency for a small one-bit step shifter.

## Interface
Parameters:
- N, default 8: data width; must be a power of two and at least 2.
- SW, default $clog2(N): shift-amount width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_data  input  N  word to shift.
- in_amount  input  SW  shift distance, 0..N-1.
- in_dir  input  1  0 = left, 1 = right.
- in_arith  input  1  1 = arithmetic right shift. Present only with ITER_SHIFTER_ARITH_EN.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  N  shifted word.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid, capture in_data into the work register, in_amount into the counter, and in_dir (and in_arith when the macro is defined).
  - Go to DONE if in_amount == 0, otherwise go to SHIFT.
- SHIFT:
  - Each cycle, work register = one-bit shift in the captured direction, and the counter decrements.
  - Left shift: zero enters bit 0.
  - Right shift: zero enters bit N-1, or the MSB is replicated when arithmetic.
  - When the counter goes from 1 to 0, go to DONE.
- DONE:
  - out_valid = 1 and out_data = work register.
  - On out_ready, go to IDLE.
- in_ready is 0 in SHIFT and DONE. Requests are not queued, and in_valid is ignored outside IDLE.
- out_data is driven from the work register at all times. It is meaningful only while out_valid is 1.
- Captured inputs are frozen. Changes to in_* after acceptance have no effect.
- Counter width is SW. in_amount of N-1 produces N-1 shifts with no wrap.
- Reset state:
  - state = IDLE, work register = 0, counter = 0.
  - Outputs after reset: in_ready = 1, out_valid = 0, out_data = 0.
- Reset mid-operation aborts the operation and discards it. No result is emitted.

## Timing
- Accept cycle = cycle 0, the cycle where in_valid and in_ready are both high.
- out_valid rises in cycle A+1, where A = captured amount. A = 0 gives out_valid in cycle 1.
- out_valid stays high and out_data stays stable until out_ready is sampled high.
- in_ready returns to 1 in the cycle after the output handshake.
- Minimum period between accepted requests: A+2 cycles.
- No combinational path from in_valid to in_ready. No combinational path from out_ready to out_valid.

## Configuration
- ITER_SHIFTER_ARITH_EN defined:
  - The in_arith port exists.
  - A right shift with in_arith = 1 replicates the captured word's MSB into bit N-1 on every step.
  - in_arith is ignored for left shifts.
- ITER_SHIFTER_ARITH_EN undefined:
  - The in_arith port is absent.
  - All right shifts are zero-filling.

## Structure
- Package iter_shift_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the constants DIR_LEFT = 1'b0 and DIR_RIGHT = 1'b1.
- Sub-module shift_step_by_one: combinational one-bit shifter, parameterised by N.
  - Inputs: word, dir, fill bit.
  - Output: shifted word.
  - The FSM selects the fill bit.

## Test plan
- N = 8: in_data 8'b1011_0101, left, amount 3 -> out_data 8'b1010_1000; out_valid first high in cycle 4.
- Same word, right, amount 3, logical -> 8'b0001_0110.
- Amount 0, in_data 8'h5A -> out_data 8'h5A with out_valid in cycle 1.
- Backpressure on 8'h0F, left, amount 4:
  - Hold out_ready low 5 cycles -> out_data stays 8'hF0, out_valid stays 1, in_ready stays 0.
  - Raise out_ready for 1 cycle -> in_ready = 1 in the next cycle.
- With ITER_SHIFTER_ARITH_EN: 8'h80, right, amount 7, in_arith = 1 -> 8'hFF; with in_arith = 0 -> 8'h01.
- Assert rst in the second SHIFT cycle of an amount-5 operation -> out_valid never rises. After release: in_ready = 1, out_data = 0, and a new request completes correctly.
